// File: rtl/mc_control.sv
// Multi-cycle control FSM for the rv32i core: sequences fetch/decode/execute/memory/writeback
// and drives ALU op, operand selects, memory strobes and register/pc write enables.
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_ctrl,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StExecI   = 4'd4,
    StAluWb   = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWb   = 4'd8,
    StMemWr   = 4'd9,
    StBranch  = 4'd10,
    StIllegal = 4'd11
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  logic r_legal, i_legal;

  always_comb begin
    unique case ({funct7, funct3})
      {7'b0000000, 3'b000}, {7'b0100000, 3'b000}, {7'b0000000, 3'b111},
      {7'b0000000, 3'b110}, {7'b0000000, 3'b001}, {7'b0000001, 3'b000}: r_legal = 1'b1;
      default: r_legal = 1'b0;
    endcase
    // funct7 is immediate data for everything except the shift
    unique case (funct3)
      3'b000, 3'b111, 3'b110: i_legal = 1'b1;
      3'b001:                 i_legal = (funct7 == 7'b0000000);
      default:                i_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    alu_ctrl   = 4'b0010;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      StIdle: begin
        alu_ctrl = 4'b0000;
        state_d  = StFetch;
      end
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        if (opcode == OpR && r_legal)                              state_d = StExecR;
        else if (opcode == OpI && i_legal)                         state_d = StExecI;
        else if ((opcode == OpLoad || opcode == OpStore) && funct3 == 3'b010)
                                                                   state_d = StMemAddr;
        else if (opcode == OpBranch && (funct3 == 3'b000 || funct3 == 3'b001))
                                                                   state_d = StBranch;
        else                                                       state_d = StIllegal;
      end
      StExecR: begin
        alu_src_a = 2'b01;
        if (funct7 == 7'b0000001)      alu_ctrl = 4'b0100;
        else if (funct7 == 7'b0100000) alu_ctrl = 4'b0110;
        else begin
          case (funct3)
            3'b111:  alu_ctrl = 4'b0000;
            3'b110:  alu_ctrl = 4'b0001;
            3'b001:  alu_ctrl = 4'b1110;
            default: alu_ctrl = 4'b0010;
          endcase
        end
        state_d = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (funct3)
          3'b111:  alu_ctrl = 4'b0000;
          3'b110:  alu_ctrl = 4'b0001;
          3'b001:  alu_ctrl = 4'b1110;
          default: alu_ctrl = 4'b0010;
        endcase
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StMemAddr: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpLoad) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StBranch: begin
        alu_src_a = 2'b01;
        alu_ctrl  = 4'b0110;
        pc_src    = 1'b1;
        pc_write  = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
        state_d   = StFetch;
      end
      StIllegal: begin
        illegal = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the rv32i core. It decodes the instruction register fields and sequences fetch, decode, execute, memory and writeback over several cycles. Each cycle it drives the `alu` block's `alu_ctrl` code and its operand selects, and it consumes the ALU `zero` flag to resolve branches. It sits between the instruction register and the datapath muxes, register file and memory port, and it waits on a single memory ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state IDLE
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- funct7  in  7  instruction register bits [31:25]
- zero  in  1  ALU equality flag (in1==in2)
- mem_ready  in  1  memory completed current read or write this cycle
- alu_ctrl  out  4  ALU op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0100 MUL, 0110 SUB, 1110 SLL
- alu_src_a  out  2  ALU in1 select:
  - 00 pc, 01 reg A (rs1), 10 old_pc
- alu_src_b  out  2  ALU in2 select:
  - 00 reg B (rs2), 01 constant 4, 10 immediate
- iord  out  1  memory address select: 0 pc, 1 aluout register
- mem_read, mem_write  out  1 each  memory strobes; held until mem_ready
- ir_write  out  1  load instruction register (and old_pc)
- pc_write  out  1  load pc
- pc_src  out  1  pc source: 0 live ALU result, 1 aluout register
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  writeback source: 0 aluout, 1 memory data register
- illegal  out  1  one-cycle pulse on an unsupported instruction
- state  out  4  current state encoding, for debug

## Operation
- Moore FSM. Outputs decode combinationally from `state`, except the branch pc_write, which also uses `zero` and `funct3`.
- Every output is 0 unless listed for a state. alu_ctrl defaults to 0010.
- State encodings and behaviour:
  - IDLE (0): all outputs 0, including alu_ctrl=0000. Next state FETCH.
  - FETCH (1): mem_read=1, iord=0, a=00, b=01, ADD. When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay with ir_write and pc_write at 0.
  - DECODE (2): a=10, b=10, ADD (branch target into aluout). Next state by opcode:
    - 0110011 → EXEC_R, if {funct7,funct3} is one of 0000000/000, 0100000/000, 0000000/111, 0000000/110, 0000000/001 or 0000001/000.
    - 0010011 → EXEC_I, if funct3 is one of 000, 111, 110, or 001 with funct7=0000000.
    - 0000011 with funct3=010, or 0100011 with funct3=010 → MEM_ADDR.
    - 1100011 with funct3 000 or 001 → BRANCH.
    - Anything else → ILLEGAL.
  - EXEC_R (3): a=01, b=00. alu_ctrl: add 0010, sub 0110, and 0000, or 0001, sll 1110, mul 0100. Next state ALU_WB.
  - EXEC_I (4): a=01, b=10. alu_ctrl: addi 0010, andi 0000, ori 0001, slli 1110. Next state ALU_WB.
  - ALU_WB (5): reg_write=1, mem_to_reg=0. Next state FETCH.
  - MEM_ADDR (6): a=01, b=10, ADD. Next state MEM_RD for a load, MEM_WR for a store.
  - MEM_RD (7): mem_read=1, iord=1. Stay until mem_ready, then MEM_WB.
  - MEM_WB (8): reg_write=1, mem_to_reg=1. Next state FETCH.
  - MEM_WR (9): mem_write=1, iord=1. Stay until mem_ready, then FETCH.
  - BRANCH (10): a=01, b=00, SUB, pc_src=1. pc_write = (funct3==000 & zero) | (funct3==001 & ~zero). Next state FETCH.
  - ILLEGAL (11): illegal=1. Next state FETCH.
- Encodings 12-15 are unreachable and recover to IDLE on the next edge.

## Timing
- Reset is asynchronous. While reset is high, state=IDLE and all outputs are 0. The first FETCH is in the cycle after reset deasserts.
- Reset asserted mid-instruction aborts it immediately; strobes drop in the same cycle.
- Latency with mem_ready always 1 (FETCH to next FETCH): R/I = 4, load = 5, store = 4, branch = 3, illegal = 3 cycles.
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Strobes, iord and address selects stay stable while waiting.
- mem_ready is ignored in all other states.
- The branch decision uses `zero` sampled in the BRANCH cycle only.

## Test plan
- Reset mid-MEM_RD with mem_ready=0: outputs 0 immediately. After release, IDLE→FETCH with mem_read=1, iord=0.
- add (opcode 0110011, f3 000, f7 0000000): states 1,2,3,5,1. alu_ctrl=0010 in EXEC_R. reg_write=1 only in ALU_WB.
  - sub (f7 0100000) gives 0110; mul (f7 0000001) gives 0100.
- lw with mem_ready low for 2 cycles in MEM_RD: mem_read=1, iord=1 held for 3 cycles, then MEM_WB with reg_write=1, mem_to_reg=1. 7 cycles total.
- beq with zero=1: pc_write=1, pc_src=1 in BRANCH. With zero=0: pc_write=0. bne is the inverse.
- Illegal encodings (opcode 1111111, and R-type f3 010): illegal pulses exactly one cycle, no reg_write, mem_read or mem_write, then FETCH.
- slli (0010011, f3 001) gives alu_ctrl=1110, a=01, b=10. slli with f7=0100000 goes to ILLEGAL.
